ticket_buyer: RTL and testbench

- Customer-side payment controller that drives the bill-insert side of the ticket machine.
- On `start`, it checks that the wallet holds at least 40 units, waits for the machine's `ready`, then inserts bills one at a time on `ten`/`twenty`.
- It checks each machine response (`bill`, `dispense`, `return_sig`) against its own running total and reports ticket, refund or error.
- It sits between the wallet/stimulus logic and the ticket machine's input pins.

---
 rtl/ticket_buyer_if.sv | 20 ++
 rtl/ticket_buyer.sv | 202 ++++++++++++++++++++
 tb/tb_ticket_buyer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ticket_buyer_if.sv
// Bill-insert link between the ticket buyer and the ticket machine.
// The buyer drives the bill pulses; the machine answers with its status lines.
interface ticket_buyer_if;
   logic ready;
   logic bill;
   logic dispense;
   logic return_sig;
   logic ten;
   logic twenty;

   modport master (
      input  ready, bill, dispense, return_sig,
      output ten, twenty
   );

   modport slave (
      output ready, bill, dispense, return_sig,
      input  ten, twenty
   );
endinterface

// File: rtl/ticket_buyer.sv
// Customer-side payment controller: checks the wallet, feeds bills to the ticket
// machine one at a time and verifies each machine response against its own total.
module ticket_buyer #(
   parameter int unsigned W       = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 clear_n,
   ticket_buyer_if.master       mach,
   input  logic                 start_i,
   input  logic                 tens_first_i,
   input  logic [W-1:0]         wallet_tens_i,
   input  logic [W-1:0]         wallet_twenties_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 ticket_o,
   output logic                 refund_o,
   output logic                 error_o,
   output logic [W-1:0]         tens_left_o,
   output logic [W-1:0]         twenties_left_o,
   output logic [5:0]           paid_o
);

   localparam int unsigned SUM_W  = W + 2;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned PAID_W = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RDY,
      S_INSERT,
      S_SETTLE,
      S_DONE,
      S_FAIL
   } state_e;

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                tens_first_q;
   logic [W-1:0]        tens_q;
   logic [W-1:0]        twenties_q;
   logic [W-1:0]        shadow_tens_q;
   logic [W-1:0]        shadow_twenties_q;
   logic [PAID_W-1:0]   paid_q;
   logic                ten_q;
   logic                twenty_q;
   logic                busy_q;
   logic                done_q;
   logic                ticket_q;
   logic                refund_q;
   logic                error_q;

   logic [SUM_W-1:0]    funds_c;
   logic [PAID_W-1:0]   need_c;
   logic                use_twenty_c;
   logic                resp_bill_c;
   logic                resp_dispense_c;
   logic                resp_return_c;
   logic                insert_c;

   // Wallet value in tens, wide enough that 2*twenties cannot wrap.
   assign funds_c = SUM_W'(wallet_tens_i) + (SUM_W'(wallet_twenties_i) << 1);
   assign need_c  = PAID_W'(40) - paid_q;

   // A response is valid only when exactly the expected status line is high.
   assign resp_bill_c     =  mach.bill & ~mach.dispense & ~mach.return_sig;
   assign resp_dispense_c = ~mach.bill &  mach.dispense & ~mach.return_sig;
   assign resp_return_c   = ~mach.bill & ~mach.dispense &  mach.return_sig;

   always_comb begin
      use_twenty_c = 1'b0;
      if (tens_first_q) begin
         use_twenty_c = (tens_q == '0);
      end else begin
         use_twenty_c = ((twenties_q != '0) && (need_c >= PAID_W'(20))) || (tens_q == '0);
      end
   end

   // Bill is pulsed and booked on the edge that enters INSERT.
   assign insert_c = ((state_q == S_WAIT_RDY) && mach.ready) ||
                     ((state_q == S_SETTLE) && (paid_q < PAID_W'(40)) && resp_bill_c);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q           <= S_IDLE;
         cnt_q             <= '0;
         tens_first_q      <= 1'b0;
         tens_q            <= '0;
         twenties_q        <= '0;
         shadow_tens_q     <= '0;
         shadow_twenties_q <= '0;
         paid_q            <= '0;
         ten_q             <= 1'b0;
         twenty_q          <= 1'b0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         ticket_q          <= 1'b0;
         refund_q          <= 1'b0;
         error_q           <= 1'b0;
      end else begin
         ten_q    <= 1'b0;
         twenty_q <= 1'b0;
         done_q   <= 1'b0;

         if (insert_c) begin
            if (use_twenty_c) begin
               twenty_q   <= 1'b1;
               twenties_q <= twenties_q - W'(1);
               paid_q     <= paid_q + PAID_W'(20);
            end else begin
               ten_q      <= 1'b1;
               tens_q     <= tens_q - W'(1);
               paid_q     <= paid_q + PAID_W'(10);
            end
         end

         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  tens_q            <= wallet_tens_i;
                  twenties_q        <= wallet_twenties_i;
                  shadow_tens_q     <= wallet_tens_i;
                  shadow_twenties_q <= wallet_twenties_i;
                  tens_first_q      <= tens_first_i;
                  paid_q            <= '0;
                  ticket_q          <= 1'b0;
                  refund_q          <= 1'b0;
                  cnt_q             <= '0;
                  busy_q            <= 1'b1;
                  if (funds_c < SUM_W'(4)) begin
                     state_q <= S_FAIL;
                     error_q <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_WAIT_RDY;
                     error_q <= 1'b0;
                  end
               end
            end

            S_WAIT_RDY: begin
               if (mach.ready) begin
                  state_q <= S_INSERT;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_q <= S_FAIL;
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            S_INSERT: begin
               state_q <= S_SETTLE;
            end

            S_SETTLE: begin
               if (insert_c) begin
                  state_q <= S_INSERT;
               end else if ((paid_q == PAID_W'(40)) && resp_dispense_c) begin
                  state_q  <= S_DONE;
                  ticket_q <= 1'b1;
                  done_q   <= 1'b1;
               end else if ((paid_q == PAID_W'(50)) && resp_return_c) begin
                  state_q    <= S_DONE;
                  refund_q   <= 1'b1;
                  done_q     <= 1'b1;
                  tens_q     <= shadow_tens_q;
                  twenties_q <= shadow_twenties_q;
               end else begin
                  // Unexpected machine response: inserted bills are forfeited.
                  state_q <= S_FAIL;
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end

            S_DONE, S_FAIL: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mach.ten        = ten_q;
   assign mach.twenty     = twenty_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign ticket_o        = ticket_q;
   assign refund_o        = refund_q;
   assign error_o         = error_q;
   assign tens_left_o     = tens_q;
   assign twenties_left_o = twenties_q;
   assign paid_o          = paid_q;

endmodule

// File: tb/tb_ticket_buyer.sv
// Bench for ticket_buyer: a behavioural ticket machine answers the bill pulses,
// expected pulses and results are queued per purchase and compared as they appear.
module tb_ticket_buyer;

   localparam int unsigned W       = 4;
   localparam int unsigned TIMEOUT = 15;

   logic         clk = 1'b0;
   logic         clear_n;
   logic         start;
   logic         tens_first;
   logic [W-1:0] wallet_tens;
   logic [W-1:0] wallet_twenties;
   logic         busy, done, ticket, refund, error;
   logic [W-1:0] tens_left, twenties_left;
   logic [5:0]   paid;

   logic ready_r;
   logic fault;
   int   m_tot;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int cyc;
      bit tw;
   } pulse_t;

   typedef struct {
      int       done_cyc;
      bit [2:0] flags;   // {ticket, refund, error}
      int       paid;
      int       tl;
      int       twl;
   } res_t;

   pulse_t exp_pulse_q[$];
   pulse_t obs_pulse_q[$];
   res_t   exp_res_q[$];

   always #5 clk = ~clk;

   ticket_buyer_if mach_if ();

   ticket_buyer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk               (clk),
      .clear_n           (clear_n),
      .mach              (mach_if),
      .start_i           (start),
      .tens_first_i      (tens_first),
      .wallet_tens_i     (wallet_tens),
      .wallet_twenties_i (wallet_twenties),
      .busy_o            (busy),
      .done_o            (done),
      .ticket_o          (ticket),
      .refund_o          (refund),
      .error_o           (error),
      .tens_left_o       (tens_left),
      .twenties_left_o   (twenties_left),
      .paid_o            (paid)
   );

   // Ticket machine: banks each bill on the edge ending INSERT, answers from its own total.
   always @(posedge clk or negedge clear_n) begin
      if (!clear_n)             m_tot <= 0;
      else if (!busy)           m_tot <= 0;
      else if (mach_if.ten)     m_tot <= m_tot + 10;
      else if (mach_if.twenty)  m_tot <= m_tot + 20;
   end

   assign mach_if.ready      = ready_r;
   assign mach_if.bill       = !fault && (m_tot > 0) && (m_tot < 40);
   assign mach_if.dispense   = fault ? (m_tot > 0) : (m_tot == 40);
   assign mach_if.return_sig = !fault && (m_tot == 50);

   task automatic test_reset();
      clear_n = 1'b0; start = 1'b0; tens_first = 1'b0;
      wallet_tens = '0; wallet_twenties = '0; ready_r = 1'b1; fault = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({mach_if.ten, mach_if.twenty, busy, done, ticket, refund, error,
           tens_left, twenties_left, paid} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: outputs=%b required all zero",
                  {mach_if.ten, mach_if.twenty, busy, done, ticket, refund, error,
                   tens_left, twenties_left, paid});
      end
      clear_n = 1'b1;
      @(negedge clk);
   endtask

   // seq: one char per expected bill ('t' ten, 'T' twenty) at first_cyc, first_cyc+2, ...
   task automatic test_purchase(input string name, input int tens, input int tw, input bit tf,
                                input int rdy_at, input bit flt, input int hold,
                                input string seq, input int first_cyc, input int done_cyc,
                                input bit [2:0] flags, input int e_paid, input int e_tl,
                                input int e_twl);
      pulse_t   p, o;
      res_t     r, e;
      bit       seen;
      int       d_cyc;
      bit [2:0] f_obs;
      int       o_paid, o_tl, o_twl;
      for (int i = 0; i < seq.len(); i++) begin
         p.cyc = first_cyc + 2 * i;
         p.tw  = (seq[i] == "T");
         exp_pulse_q.push_back(p);
      end
      r.done_cyc = done_cyc; r.flags = flags; r.paid = e_paid; r.tl = e_tl; r.twl = e_twl;
      exp_res_q.push_back(r);
      obs_pulse_q.delete();

      @(negedge clk);
      ready_r = (rdy_at == 0); fault = flt; tens_first = tf;
      wallet_tens = W'(tens); wallet_twenties = W'(tw); start = 1'b1;
      seen = 1'b0; d_cyc = -1; f_obs = '0; o_paid = 0; o_tl = 0; o_twl = 0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         @(negedge clk);
         if (c >= hold) start = 1'b0;
         if (c == rdy_at) ready_r = 1'b1;
         if (mach_if.ten && mach_if.twenty) begin
            n_checks++; n_fail++;
            $display("FAIL %s both_lines: ten and twenty high together in c%0d", name, c);
         end
         if (mach_if.ten || mach_if.twenty) begin
            o.cyc = c; o.tw = mach_if.twenty;
            obs_pulse_q.push_back(o);
         end
         if (done) begin
            seen = 1'b1; d_cyc = c; f_obs = {ticket, refund, error};
            o_paid = int'(paid); o_tl = int'(tens_left); o_twl = int'(twenties_left);
         end
      end
      start = 1'b0; fault = 1'b0; ready_r = 1'b1;

      e = exp_res_q.pop_front();
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s done_timeout: no done within 60 cycles, required c%0d", name, e.done_cyc);
      end else if (d_cyc != e.done_cyc) begin
         n_fail++;
         $display("FAIL %s done_cycle: got c%0d required c%0d", name, d_cyc, e.done_cyc);
      end
      n_checks++;
      if (f_obs !== e.flags) begin
         n_fail++;
         $display("FAIL %s result_flags: got %b required %b (ticket,refund,error)", name, f_obs, e.flags);
      end
      n_checks++;
      if (o_paid != e.paid || o_tl != e.tl || o_twl != e.twl) begin
         n_fail++;
         $display("FAIL %s totals: paid/tens/twenties got %0d/%0d/%0d required %0d/%0d/%0d",
                  name, o_paid, o_tl, o_twl, e.paid, e.tl, e.twl);
      end
      n_checks++;
      if (obs_pulse_q.size() != exp_pulse_q.size()) begin
         n_fail++;
         $display("FAIL %s pulse_count: got %0d required %0d", name, obs_pulse_q.size(), exp_pulse_q.size());
      end
      while (exp_pulse_q.size() > 0 && obs_pulse_q.size() > 0) begin
         p = exp_pulse_q.pop_front();
         o = obs_pulse_q.pop_front();
         n_checks++;
         if (o.cyc != p.cyc || o.tw != p.tw) begin
            n_fail++;
            $display("FAIL %s pulse: got %s in c%0d required %s in c%0d", name,
                     o.tw ? "twenty" : "ten", o.cyc, p.tw ? "twenty" : "ten", p.cyc);
         end
      end
      exp_pulse_q.delete();
      obs_pulse_q.delete();

      if (seen) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0 || {ticket, refund, error} !== e.flags) begin
            n_fail++;
            $display("FAIL %s after_done: busy=%b done=%b flags=%b required 0/0/%b",
                     name, busy, done, {ticket, refund, error}, e.flags);
         end
      end
   endtask

   // Abort mid-purchase: once while a twenty is on the line, once in SETTLE.
   task automatic test_reset_mid();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         ready_r = 1'b1; tens_first = 1'b0; wallet_tens = '0; wallet_twenties = W'(2);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         if (k == 1) @(negedge clk);
         n_checks++;
         if (busy !== 1'b1 || paid !== 6'd20 || twenties_left !== W'(1) || mach_if.twenty !== (k == 0)) begin
            n_fail++;
            $display("FAIL reset_mid_pre%0d: busy=%b paid=%0d twenties_left=%0d twenty=%b required 1/20/1/%b",
                     k, busy, paid, twenties_left, mach_if.twenty, (k == 0));
         end
         clear_n = 1'b0;
         #1;
         n_checks++;
         if ({mach_if.ten, mach_if.twenty, busy, done, ticket, refund, error,
              tens_left, twenties_left, paid} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async%0d: outputs=%b required all zero", k,
                     {mach_if.ten, mach_if.twenty, busy, done, ticket, refund, error,
                      tens_left, twenties_left, paid});
         end
         @(negedge clk);
         clear_n = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_purchase("twenties_only",  0, 2, 1'b0, 0, 1'b0, 1, "TT",   2,  6, 3'b100, 40, 0, 0);
      test_purchase("prefer_twenty",  3, 1, 1'b0, 0, 1'b0, 1, "Ttt",  2,  8, 3'b100, 40, 1, 0);
      test_purchase("prefer_ten",     3, 1, 1'b1, 0, 1'b0, 1, "tttT", 2, 10, 3'b010, 50, 3, 1);
      test_purchase("no_funds",       1, 1, 1'b0, 0, 1'b0, 1, "",     2,  1, 3'b001,  0, 1, 1);
      test_purchase("funds_three",    3, 0, 1'b0, 0, 1'b0, 1, "",     2,  1, 3'b001,  0, 3, 0);
      test_purchase("tens_only",      5, 0, 1'b0, 0, 1'b0, 1, "tttt", 2, 10, 3'b100, 40, 1, 0);
      test_purchase("mixed_refund",   1, 2, 1'b1, 0, 1'b0, 1, "tTT",  2,  8, 3'b010, 50, 1, 2);
      test_purchase("tens_then_tw",   2, 1, 1'b1, 0, 1'b0, 1, "ttT",  2,  8, 3'b100, 40, 0, 0);
      test_purchase("full_wallet",   15,15, 1'b1, 0, 1'b0, 1, "tttt", 2, 10, 3'b100, 40, 11, 15);
      test_purchase("timeout",        4, 0, 1'b0, 99,1'b0, 1, "",     2, 16, 3'b001,  0, 4, 0);
      test_purchase("ready_late_ok",  0, 2, 1'b0, 15,1'b0, 1, "TT",  16, 20, 3'b100, 40, 0, 0);
      test_purchase("ready_too_late", 0, 2, 1'b0, 16,1'b0, 1, "",     2, 16, 3'b001,  0, 0, 2);
      test_purchase("proto_fault",    0, 2, 1'b0, 0, 1'b1, 1, "T",    2,  4, 3'b001, 20, 0, 1);
      test_purchase("start_held",     3, 1, 1'b0, 0, 1'b0, 5, "Ttt",  2,  8, 3'b100, 40, 1, 0);
      test_reset_mid();
      test_purchase("after_reset",    1, 3, 1'b0, 0, 1'b0, 1, "TT",   2,  6, 3'b100, 40, 1, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
